// File: rtl/fetch_pc_if.sv
// fetch_pc_if: instruction-memory req/ack port between the fetch unit and imem.
interface fetch_pc_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: PC sequencer that fetches one word per instruction and resolves branch/jump targets.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_pc_if.master  imem,
  output logic [31:0] o_instr,
  output logic        o_instr_valid,
  output logic [31:0] o_pc,
  input  logic        i_stall,
  input  logic        i_branch,
  input  logic        i_baln,
  input  logic        i_jump,
  input  logic        i_jpc,
  input  logic        i_bltzal,
  input  logic        i_link,
  input  logic        i_zero,
  input  logic        i_alu_neg,
  input  logic        i_status_n,
  output logic [31:0] o_link_addr,
  output logic        o_link_wr,
  output logic        o_fetch_err
);
  localparam int CW = FETCH_TIMEOUT > 1 ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT > 0 ? FETCH_TIMEOUT - 1 : 0);
  typedef enum logic [1:0] {S_RST, S_REQ, S_EXEC, S_ERR} state_t;
  state_t          r_state;
  logic [31:0]     r_pc;
  logic [31:0]     r_instr;
  logic [CW-1:0]   r_cnt;
  logic            r_req;
  logic            r_valid;
  logic            r_err;
  logic [31:0]     w_pc4;
  logic [31:0]     w_btgt;
  logic [31:0]     w_jtgt;
  logic [31:0]     w_next_pc;
  logic            w_take;
  logic            w_timeout;
  assign w_pc4   = r_pc + 32'd4;
  assign w_btgt  = w_pc4 + {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_jtgt  = {w_pc4[31:28], r_instr[25:0], 2'b00};
  // jumps already win by priority, so the beq term only needs to exclude baln/bltzal
  assign w_take  = (i_baln & i_status_n) | (i_bltzal & i_alu_neg) |
                   (i_branch & ~i_baln & ~i_bltzal & i_zero);
  assign w_next_pc = (i_jump | i_jpc) ? w_jtgt : (w_take ? w_btgt : w_pc4);
  assign w_timeout = (FETCH_TIMEOUT != 0) && (r_cnt == CNT_LAST);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
      r_pc    <= RESET_PC & ~32'h3;
      r_instr <= '0;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_RST: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
        end
        S_REQ: begin
          if (imem.ack) begin
            r_instr <= imem.rdata;
            r_cnt   <= '0;
            r_state <= S_EXEC;
            r_req   <= 1'b0;
            r_valid <= 1'b1;
          end else if (w_timeout) begin
            r_state <= S_ERR;
            r_req   <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_EXEC: begin
          if (!i_stall) begin
            r_pc    <= w_next_pc;
            r_state <= S_REQ;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
  assign imem.req      = r_req;
  assign imem.addr     = r_pc;
  assign o_instr       = r_instr;
  assign o_instr_valid = r_valid;
  assign o_pc          = r_pc;
  assign o_link_addr   = w_pc4;
  assign o_link_wr     = r_valid & i_link & ~i_stall;
  assign o_fetch_err   = r_err;
endmodule
